mux81_scheduler: RTL



---
 rtl/mux81_sched_pkg.sv | 13 +
 rtl/rr_pick.sv | 25 ++
 rtl/mux81_scheduler.sv | 118 +++++++++++
 3 files changed

// File: rtl/mux81_sched_pkg.sv
// Shared types and constants for the MUX81 round-robin scheduler.
package mux81_sched_pkg;

  localparam int unsigned N_SRC = 8;
  localparam int unsigned SEL_W = 3;

  typedef enum logic [1:0] {IDLE, SETUP, ACTIVE, GAP} sched_state_t;

  function automatic logic [N_SRC-1:0] onehot(input logic [SEL_W-1:0] idx);
    return N_SRC'(1) << idx;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin priority encoder: first set req bit after last, wrapping,
// with bit `last` itself considered last.
module rr_pick
  import mux81_sched_pkg::*;
(
  input  logic [N_SRC-1:0] req_i,
  input  logic [SEL_W-1:0] last_i,
  output logic             any_o,
  output logic [SEL_W-1:0] idx_o
);

  logic [SEL_W-1:0] pos;

  always_comb begin
    any_o = |req_i;
    idx_o = last_i;
    pos   = '0;
    // Scan from the far end so the nearest set bit after last_i wins.
    for (int k = N_SRC; k >= 1; k--) begin
      pos = last_i + SEL_W'(k);
      if (req_i[pos]) idx_o = pos;
    end
  end

endmodule

// File: rtl/mux81_scheduler.sv
// Shares an 8-to-1 mux among 8 requesters: round-robin grants with a setup cycle,
// programmable dwell and a break-before-make gap.
module mux81_scheduler
  import mux81_sched_pkg::*;
#(
  parameter int unsigned DWELL_W = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [N_SRC-1:0]   req_i,
  input  logic [DWELL_W-1:0] dwell_i,
  output logic [SEL_W-1:0]   select_o,
  output logic               enable_b_o,
  output logic [N_SRC-1:0]   grant_o,
  output logic               sample_o,
  output logic               busy_o
);

  sched_state_t       state_q, state_d;
  logic [SEL_W-1:0]   select_q, select_d;
  logic [SEL_W-1:0]   last_q, last_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [N_SRC-1:0]   grant_q, grant_d;
  logic               enable_b_q, enable_b_d;
  logic               busy_q, busy_d;

  logic               pick_any;
  logic [SEL_W-1:0]   pick_idx;
  logic [DWELL_W-1:0] dwell_m1;
  logic               req_cur;

  rr_pick u_rr_pick (
    .req_i  (req_i),
    .last_i (last_q),
    .any_o  (pick_any),
    .idx_o  (pick_idx)
  );

  // A dwell of 0 behaves as 1.
  assign dwell_m1 = (dwell_i == '0) ? '0 : dwell_i - DWELL_W'(1);
  // select_q holds the current winner for the whole grant.
  assign req_cur  = req_i[select_q];

  always_comb begin
    state_d    = state_q;
    select_d   = select_q;
    last_d     = last_q;
    cnt_d      = cnt_q;
    grant_d    = grant_q;
    enable_b_d = enable_b_q;
    case (state_q)
      IDLE, GAP: begin
        if (pick_any) begin
          state_d  = SETUP;
          select_d = pick_idx;
          grant_d  = onehot(pick_idx);
          last_d   = pick_idx;
          cnt_d    = dwell_m1;
        end else begin
          state_d  = IDLE;
        end
        enable_b_d = 1'b1;
      end
      SETUP: begin
        if (req_cur) begin
          state_d    = ACTIVE;
          enable_b_d = 1'b0;
        end else begin
          state_d = GAP;
          grant_d = '0;
        end
      end
      ACTIVE: begin
        if (cnt_q == '0 || !req_cur) begin
          state_d    = GAP;
          enable_b_d = 1'b1;
          grant_d    = '0;
        end else begin
          cnt_d = cnt_q - DWELL_W'(1);
        end
      end
      default: begin
        state_d    = IDLE;
        enable_b_d = 1'b1;
        grant_d    = '0;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      select_q   <= '0;
      last_q     <= SEL_W'(N_SRC - 1);
      cnt_q      <= '0;
      grant_q    <= '0;
      enable_b_q <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      select_q   <= select_d;
      last_q     <= last_d;
      cnt_q      <= cnt_d;
      grant_q    <= grant_d;
      enable_b_q <= enable_b_d;
      busy_q     <= busy_d;
    end
  end

  assign select_o   = select_q;
  assign enable_b_o = enable_b_q;
  assign grant_o    = grant_q;
  assign busy_o     = busy_q;
  // Withheld if the source drops its request in the final cycle.
  assign sample_o   = (state_q == ACTIVE) && (cnt_q == '0) && req_cur;

endmodule
